occupancy_sensor_gen: RTL and testbench
=======================================

# occupancy_sensor_gen

Stimulus generator that drives the two photo-sensor lines of the parking-lot occupancy counter. It is the encoder counterpart to the sensor-decoding FSM: given a direction and a car count, it produces the exact a/b blocking sequence of cars entering or exiting. It runs in a self-test top in place of the physical sensors, or as a bench driver. Each phase is held long enough to pass through the debouncers.

## Interface
Parameters:
- STEP_CYCLES, 5_000_000: clock cycles each sensor phase is held (50 ms at 100 MHz, longer than the debounce time); ≥1
- GAP_CYCLES, 5_000_000: idle (a=b=0) cycles between consecutive cars in a burst; ≥1
- NUM_W, 8: width of the car-count input

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  request a burst; honoured only when ready=1
- dir  in  1  0 = entering cars, 1 = exiting cars; latched on accept
- num  in  NUM_W  number of cars in the burst; latched on accept
- ready  out  1  high when idle and able to accept start
- a  out  1  outer sensor line, 1 = blocked
- b  out  1  inner sensor line, 1 = blocked
- car_done  out  1  one-cycle tick when each car completes
- done  out  1  one-cycle tick when the burst completes

## Operation
- States: IDLE, PH1, PH2, PH3, GAP.
- Phase encoding {a,b}:
  - Entry: PH1 = 10, PH2 = 11, PH3 = 01.
  - Exit: PH1 = 01, PH2 = 11, PH3 = 10.
  - IDLE and GAP = 00.
- IDLE, start=1:
  - num≠0: latch dir and num into the remaining-cars register and go to PH1.
  - num=0: stay in IDLE, pulse done for one cycle, keep ready=1, keep a/b at 00, no car_done.
- PH1→PH2→PH3: each transition occurs after STEP_CYCLES cycles.
- PH3 expiry: pulse car_done and decrement remaining.
  - remaining was 1: go to IDLE and pulse done in the same cycle.
  - Otherwise: go to GAP.
- GAP expiry after GAP_CYCLES cycles: go to PH1 with the same latched dir.
- start, dir and num are ignored while ready=0. A burst cannot be aborted except by reset.
- Reset asserted, at any time including mid-phase:
  - a=b=0, ready=1, car_done=done=0, state IDLE, timer and remaining cleared.
  - Outputs change asynchronously.
  - The interrupted burst never signals done.
- Width rules:
  - Phase timer width is $clog2(max(STEP_CYCLES, GAP_CYCLES)+1).
  - The remaining-cars register is NUM_W bits and never wraps; it is only decremented when ≥1.

## Timing
- All outputs are registered and glitch-free. a and b never change in the same cycle except 11↔00, which never occurs directly.
- Let start be accepted at edge k:
  - ready=0 and PH1 appear at edge k.
  - PH2 starts at k+STEP_CYCLES.
  - PH3 starts at k+2·STEP_CYCLES.
  - 00 plus car_done at k+3·STEP_CYCLES.
- Burst duration, from accept edge to done edge: num·3·STEP_CYCLES + (num−1)·GAP_CYCLES cycles.
- done and ready=1 assert at the same edge. A new start sampled on the following edge is accepted, so back-to-back bursts have zero dead cycles beyond that edge.
- car_done and done are exactly one cycle wide.

## Structure
- Shared package occ_pkg holds:
  - the state enum (IDLE, PH1, PH2, PH3, GAP);
  - the direction constants DIR_ENTER=0 and DIR_EXIT=1;
  - the 2-bit phase codes for entry and exit, also reused by the decoder bench.
- One sub-module, phase_timer:
  - a loadable down-counter with a load value input and a one-cycle expire output;
  - parameterised by width;
  - same clk and reset as this block.
- The top of this block contains the FSM, the dir/remaining registers and the output encoding.

## Test plan
Use STEP_CYCLES=4, GAP_CYCLES=3 unless stated.
1. Reset low → a=b=0, ready=1, done=car_done=0; hold for 5 cycles with start=1: no activity.
2. start, dir=0, num=1 → {a,b} = 10 ×4, 11 ×4, 01 ×4, then 00. car_done and done high in the same single cycle, ready=1 that cycle; 12 busy cycles total.
3. start, dir=1, num=3 → three 01/11/10 sequences separated by 3 cycles of 00. car_done ×3, done ×1 at cycle 42 after accept.
4. During test 3, pulse start with dir=0, num=7 → ignored: direction stays exit, exactly 3 cars.
5. start with num=0 → done one cycle later, ready stays 1, a=b=0 throughout.
6. Reset driven low in the 2nd cycle of PH2 → a=b=0 immediately, no done. After release, ready=1 and a new num=1 burst runs normally.

Source files
------------

// File: rtl/occ_pkg.sv
// rtl/occ_pkg.sv - shared states, direction constants and phase codes for the occupancy sensor blocks
package occ_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } occ_state_e;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // {a,b} codes: a is the outer sensor, b the inner one.
    localparam logic [1:0] AB_IDLE   = 2'b00;
    localparam logic [1:0] ENTER_PH1 = 2'b10;
    localparam logic [1:0] ENTER_PH2 = 2'b11;
    localparam logic [1:0] ENTER_PH3 = 2'b01;
    localparam logic [1:0] EXIT_PH1  = 2'b01;
    localparam logic [1:0] EXIT_PH2  = 2'b11;
    localparam logic [1:0] EXIT_PH3  = 2'b10;

    function automatic logic [1:0] phase_code(input occ_state_e s, input logic d);
        logic [1:0] code;
        code = AB_IDLE;
        case (s)
            PH1:     code = (d == DIR_EXIT) ? EXIT_PH1 : ENTER_PH1;
            PH2:     code = (d == DIR_EXIT) ? EXIT_PH2 : ENTER_PH2;
            PH3:     code = (d == DIR_EXIT) ? EXIT_PH3 : ENTER_PH3;
            default: code = AB_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with a one-cycle expire flag
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   load_i     load load_val_i and start counting
//   load_val_i cycles-minus-one until expire
//   expire_o   high for the single cycle in which a loaded count reaches zero
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    // Loading N-1 makes expire appear N cycles after the load edge.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = load_val_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/occupancy_sensor_gen.sv
// rtl/occupancy_sensor_gen.sv - drives a/b photo-sensor lines with car entry/exit sequences
// Ports:
//   clk, reset (async active-low)
//   start/dir/num   burst request, sampled only while ready=1
//   ready           idle and accepting a burst
//   a, b            outer/inner sensor lines, 1 = blocked
//   car_done, done  one-cycle ticks per car and per burst
module occupancy_sensor_gen
    import occ_pkg::*;
#(
    parameter int STEP_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int NUM_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [NUM_W-1:0] num,
    output logic             ready,
    output logic             a,
    output logic             b,
    output logic             car_done,
    output logic             done
);

    localparam int MAX_CYC = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

    occ_state_e       state_q, state_d;
    logic             dir_q, dir_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [1:0]       ab_q, ab_d;
    logic             ready_q, ready_d;
    logic             car_done_q, car_done_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expire;

    phase_timer #(.W(TW)) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        rem_d      = rem_q;
        car_done_d = 1'b0;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = STEP_LD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num != '0) begin
                        dir_d    = dir;
                        rem_d    = num;
                        state_d  = PH1;
                        tmr_load = 1'b1;
                    end else begin
                        // Empty burst completes immediately without leaving IDLE.
                        done_d = 1'b1;
                    end
                end
            end
            PH1: begin
                if (tmr_expire) begin
                    state_d  = PH2;
                    tmr_load = 1'b1;
                end
            end
            PH2: begin
                if (tmr_expire) begin
                    state_d  = PH3;
                    tmr_load = 1'b1;
                end
            end
            PH3: begin
                if (tmr_expire) begin
                    car_done_d = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - NUM_W'(1);
                    end
                    if (rem_q <= NUM_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    state_d  = PH1;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are encoded from the next state so they register on the same edge as the state.
        ab_d    = phase_code(state_d, dir_d);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_ENTER;
            rem_q      <= '0;
            ab_q       <= AB_IDLE;
            ready_q    <= 1'b1;
            car_done_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            rem_q      <= rem_d;
            ab_q       <= ab_d;
            ready_q    <= ready_d;
            car_done_q <= car_done_d;
            done_q     <= done_d;
        end
    end

    assign a        = ab_q[1];
    assign b        = ab_q[0];
    assign ready    = ready_q;
    assign car_done = car_done_q;
    assign done     = done_q;

endmodule

// File: tb/tb_occupancy_sensor_gen.sv
// tb/tb_occupancy_sensor_gen.sv - directed self-checking bench for occupancy_sensor_gen
module tb_occupancy_sensor_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir;
    logic [7:0] num;
    logic       ready, a, b, car_done, done;

    int nvec = 0;
    int nerr = 0;

    occupancy_sensor_gen #(
        .STEP_CYCLES (4),
        .GAP_CYCLES  (3),
        .NUM_W       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dir      (dir),
        .num      (num),
        .ready    (ready),
        .a        (a),
        .b        (b),
        .car_done (car_done),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-written phase table: index 0..2 = PH1..PH3.
    function automatic logic [1:0] code(input logic d, input int p);
        logic [1:0] c;
        if (d == 1'b0) begin
            c = (p == 0) ? 2'b10 : (p == 1) ? 2'b11 : 2'b01;
        end else begin
            c = (p == 0) ? 2'b01 : (p == 1) ? 2'b11 : 2'b10;
        end
        return c;
    endfunction

    // Called at the first negedge after the accept edge. Each car spans 12 phase
    // cycles plus 3 gap cycles; the last car has no gap.
    task automatic run_burst(input logic d, input int n, input int ignore_at);
        int total;
        int w;
        int cd;
        logic [1:0] e;
        total = n * 12 + (n - 1) * 3;
        cd = 0;
        for (int t = 0; t < total; t++) begin
            w = t % 15;
            e = (w < 12) ? code(d, w / 4) : 2'b00;
            chk($sformatf("ab t=%0d", t), {30'd0, a, b}, {30'd0, e});
            chk($sformatf("car_done t=%0d", t), {31'd0, car_done}, {31'd0, (w == 12)});
            chk($sformatf("done t=%0d", t), {31'd0, done}, 32'd0);
            chk($sformatf("ready t=%0d", t), {31'd0, ready}, 32'd0);
            if (car_done) cd++;
            if (t == ignore_at) begin
                start = 1'b1;
                dir   = ~d;
                num   = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("end ab", {30'd0, a, b}, 32'd0);
        chk("end car_done", {31'd0, car_done}, 32'd1);
        chk("end done", {31'd0, done}, 32'd1);
        chk("end ready", {31'd0, ready}, 32'd1);
        if (car_done) cd++;
        chk("car count", cd, n);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        dir   = 1'b0;
        num   = 8'd1;

        // 1: held in reset with start high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst ab", {30'd0, a, b}, 32'd0);
            chk("rst ready", {31'd0, ready}, 32'd1);
            chk("rst done", {31'd0, done}, 32'd0);
            chk("rst car_done", {31'd0, car_done}, 32'd0);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst ready", {31'd0, ready}, 32'd1);

        // 2: single entering car
        start = 1'b1; dir = 1'b0; num = 8'd1;
        @(negedge clk);
        run_burst(1'b0, 1, -1);

        // 3+4: three exiting cars, conflicting start mid-burst
        start = 1'b1; dir = 1'b1; num = 8'd3;
        @(negedge clk);
        run_burst(1'b1, 3, 5);

        // 5: num=0 issued on the edge right after done
        start = 1'b1; dir = 1'b0; num = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero done", {31'd0, done}, 32'd1);
        chk("zero ready", {31'd0, ready}, 32'd1);
        chk("zero ab", {30'd0, a, b}, 32'd0);
        chk("zero car_done", {31'd0, car_done}, 32'd0);
        @(negedge clk);
        chk("zero done clr", {31'd0, done}, 32'd0);
        chk("zero ready2", {31'd0, ready}, 32'd1);
        chk("zero ab2", {30'd0, a, b}, 32'd0);

        // 6: reset in the 2nd cycle of PH2
        start = 1'b1; dir = 1'b0; num = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-abort ab", {30'd0, a, b}, 32'd3);
        reset = 1'b0;
        #1;
        chk("abort ab", {30'd0, a, b}, 32'd0);
        chk("abort ready", {31'd0, ready}, 32'd1);
        chk("abort done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort hold done", {31'd0, done}, 32'd0);
            chk("abort hold car_done", {31'd0, car_done}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel ready", {31'd0, ready}, 32'd1);
        chk("rel ab", {30'd0, a, b}, 32'd0);
        chk("rel done", {31'd0, done}, 32'd0);
        start = 1'b1; dir = 1'b0; num = 8'd1;
        @(negedge clk);
        run_burst(1'b0, 1, -1);
        @(negedge clk);
        chk("final done clr", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
